// File: rtl/keypad_scan_if.sv
// Keypad pin and key-vector bundle between the scanner and its environment.
interface keypad_scan_if;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] key;
    logic [15:0] key_press;
    logic        frame_done;

    modport master (input row_in, output col_out, key, key_press, frame_done);
    modport slave  (output row_in, input col_out, key, key_press, frame_done);
endinterface

// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner with whole-frame debounce and press strobes.
module keypad_scan #(
    parameter int SCAN_DIV        = 50_000,
    parameter int DEBOUNCE_FRAMES = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    keypad_scan_if.master kp
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_FRAMES);

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_q, col_d;
    logic [3:0]       col_out_q, col_out_d;
    logic [3:0]       sync1_q, sync2_q;
    logic [15:0]      raw_q, raw_d;
    logic [15:0]      cand_q, cand_d;
    logic [CNT_W-1:0] stab_q, stab_d;
    logic [15:0]      key_q, key_d;
    logic [15:0]      press_q, press_d;
    logic             sample;
    logic             frame_end;

    assign sample    = (div_q == DIV_LAST);
    assign frame_end = sample && (col_q == 2'd3);

    always_comb begin
        div_d     = sample ? '0 : div_q + 1'b1;
        col_d     = sample ? col_q + 2'd1 : col_q;
        col_out_d = ~(4'b0001 << col_d);
        raw_d     = raw_q;
        // raw_d doubles as the completed frame: column 3 is merged in the same cycle
        if (sample) begin
            for (int r = 0; r < 4; r++) begin
                raw_d[{2'(r), col_q}] = ~sync2_q[r];
            end
        end
    end

    always_comb begin
        cand_d = cand_q;
        stab_d = stab_q;
        key_d  = key_q;
        if (frame_end) begin
            if (raw_d != cand_q) begin
                cand_d = raw_d;
                stab_d = CNT_W'(1);
            end else if (stab_q < CNT_MAX) begin
                stab_d = stab_q + 1'b1;
            end
            if (stab_d == CNT_MAX) begin
                key_d = raw_d;
            end
        end
        press_d = key_d & ~key_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            col_q     <= 2'd0;
            col_out_q <= 4'b1110;
            sync1_q   <= 4'b1111;
            sync2_q   <= 4'b1111;
            raw_q     <= '0;
            cand_q    <= '0;
            stab_q    <= '0;
            key_q     <= '0;
            press_q   <= '0;
        end else begin
            div_q     <= div_d;
            col_q     <= col_d;
            col_out_q <= col_out_d;
            sync1_q   <= kp.row_in;
            sync2_q   <= sync1_q;
            raw_q     <= raw_d;
            cand_q    <= cand_d;
            stab_q    <= stab_d;
            key_q     <= key_d;
            press_q   <= press_d;
        end
    end

    assign kp.col_out    = col_out_q;
    assign kp.key        = key_q;
    assign kp.key_press  = press_q;
    assign kp.frame_done = frame_end;
endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a DEBOUNCE_FRAMES=3 scanner and a DEBOUNCE_FRAMES=1 scanner run side by side.
module tb_keypad_scan;
    localparam int SD = 4;
    localparam int FR = 4 * SD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] press_a, press_b;

    always #5 clk = ~clk;

    keypad_scan_if ifa ();
    keypad_scan_if ifb ();

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(3)) dut_a (.clk(clk), .rst_n(rst_n), .kp(ifa));
    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(1)) dut_b (.clk(clk), .rst_n(rst_n), .kp(ifb));

    // A row reads low when a held key sits on the currently driven column.
    function automatic logic [3:0] rows(input logic [15:0] p, input logic [3:0] c);
        logic [3:0] r;
        r[0] = ~|(p[3:0]   & ~c);
        r[1] = ~|(p[7:4]   & ~c);
        r[2] = ~|(p[11:8]  & ~c);
        r[3] = ~|(p[15:12] & ~c);
        return r;
    endfunction

    assign ifa.row_in = rows(press_a, ifa.col_out);
    assign ifb.row_in = rows(press_b, ifb.col_out);

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          phase = 0;
    int          kp0_pulses = 0;
    logic [15:0] hist [2][8];
    int          nf   [2];
    int          dval [2];
    logic [15:0] ek   [2];
    logic [15:0] ep   [2];

    function automatic logic [15:0] frame_a(input int ph, input int k);
        if (ph != 0)  return 16'h0200;
        if (k < 4)    return 16'h0000;
        if (k <= 8)   return 16'h0200;
        if (k <= 12)  return 16'h0000;
        if (k <= 14)  return 16'h0001;
        if (k == 15)  return 16'h0000;
        if (k <= 18)  return 16'h0001;
        if (k <= 21)  return 16'h0000;
        if (k <= 25)  return 16'h0420;
        return 16'h0200;
    endfunction

    function automatic logic [15:0] frame_b(input int k);
        return (k % 2 == 1) ? 16'h8000 : 16'h0000;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (phase %0d cycle %0d): got %h, expected %h", nm, phase, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            nf[i] = 0;
            ek[i] = '0;
            ep[i] = '0;
            for (int j = 0; j < 8; j++) hist[i][j] = '0;
        end
    endtask

    // key takes a frame's value once the last dval frames are all identical
    task automatic model_frame(input int i, input logic [15:0] f);
        bit same;
        for (int j = 7; j > 0; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = f;
        nf[i]++;
        ep[i] = '0;
        if (nf[i] >= dval[i]) begin
            same = 1'b1;
            for (int j = 0; j < dval[i]; j++) if (hist[i][j] != f) same = 1'b0;
            if (same) begin
                ep[i] = f & ~ek[i];
                ek[i] = f;
            end
        end
    endtask

    task automatic step();
        logic [3:0] ecol;
        logic       efd;
        int         k;
        ecol = ~(4'b0001 << ((cyc / SD) % 4));
        efd  = ((cyc % FR) == FR - 1);
        chk("a_col_out",    {12'd0, ifa.col_out},    {12'd0, ecol});
        chk("a_frame_done", {15'd0, ifa.frame_done}, {15'd0, efd});
        chk("a_key",        ifa.key,                 ek[0]);
        chk("a_key_press",  ifa.key_press,           ep[0]);
        chk("b_col_out",    {12'd0, ifb.col_out},    {12'd0, ecol});
        chk("b_frame_done", {15'd0, ifb.frame_done}, {15'd0, efd});
        chk("b_key",        ifb.key,                 ek[1]);
        chk("b_key_press",  ifb.key_press,           ep[1]);
        if (phase == 0 && ifa.key_press[0]) kp0_pulses++;
        if (efd) begin
            k = cyc / FR;
            model_frame(0, frame_a(phase, k));
            model_frame(1, frame_b(k));
            press_a = frame_a(phase, k + 1);
            press_b = frame_b(k + 1);
        end else begin
            ep[0] = '0;
            ep[1] = '0;
        end
    endtask

    task automatic pins();
        if (phase == 0) begin
            case (cyc)
                3:   chk("pin_walk_c3", {12'd0, ifa.col_out}, 16'h000E);
                4:   chk("pin_walk_c4", {12'd0, ifa.col_out}, 16'h000D);
                15:  chk("pin_first_frame_done", {15'd0, ifa.frame_done}, 16'h0001);
                32: begin
                    chk("pin_min_deb_key", ifb.key, 16'h8000);
                    chk("pin_min_deb_press", ifb.key_press, 16'h8000);
                end
                111: chk("pin_single_before", ifa.key, 16'h0000);
                112: begin
                    chk("pin_single_key", ifa.key, 16'h0200);
                    chk("pin_single_press", ifa.key_press, 16'h0200);
                end
                113: chk("pin_single_press_end", ifa.key_press, 16'h0000);
                192: begin
                    chk("pin_release_key", ifa.key, 16'h0000);
                    chk("pin_release_press", ifa.key_press, 16'h0000);
                end
                303: chk("pin_bounce_before", ifa.key, 16'h0000);
                304: begin
                    chk("pin_bounce_key", ifa.key, 16'h0001);
                    chk("pin_bounce_press", ifa.key_press, 16'h0001);
                end
                400: begin
                    chk("pin_two_key", ifa.key, 16'h0420);
                    chk("pin_two_press", ifa.key_press, 16'h0420);
                end
                472: chk("pin_bounce_pulse_count", 16'(kp0_pulses), 16'h0001);
                473: chk("pin_pre_reset_key", ifa.key, 16'h0200);
                default: ;
            endcase
        end else begin
            case (cyc)
                47: chk("pin_rearm_before", ifa.key, 16'h0000);
                48: begin
                    chk("pin_rearm_key", ifa.key, 16'h0200);
                    chk("pin_rearm_press", ifa.key_press, 16'h0200);
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        bit done;
        done    = 1'b0;
        dval[0] = 3;
        dval[1] = 1;
        rst_n   = 1'b0;
        press_a = frame_a(0, 0);
        press_b = frame_b(0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_col_out", {12'd0, ifa.col_out}, 16'h000E);
        chk("reset_key", ifa.key, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        for (int it = 0; it < 4000 && !done; it++) begin
            #1;
            pins();
            step();
            if (phase == 0 && cyc == 473) begin
                // asynchronous reset between edges while column 2 is driven
                #2 rst_n = 1'b0;
                #1;
                chk("midrst_col_out", {12'd0, ifa.col_out}, 16'h000E);
                chk("midrst_key", ifa.key, 16'h0000);
                chk("midrst_press", ifa.key_press, 16'h0000);
                chk("midrst_frame_done", {15'd0, ifa.frame_done}, 16'h0000);
                chk("midrst_b_col_out", {12'd0, ifb.col_out}, 16'h000E);
                model_reset();
                press_a = frame_a(1, 0);
                press_b = frame_b(0);
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                cyc   = 0;
                phase = 1;
            end else if (phase == 1 && cyc == 80) begin
                done = 1'b1;
            end else begin
                @(posedge clk);
                cyc++;
                @(negedge clk);
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_bound: sequence did not complete, phase %0d cycle %0d", phase, cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans a 4x4 active-low matrix keypad, debounces the result, and produces the 16-bit key-level vector consumed by the game core's `key[15:0]` input. The block also gives a one-cycle press strobe per key. It sits between the board keypad pins and the game state machine, in the system clock domain.

## Interface
- `SCAN_DIV`, 50_000: clock cycles each column is driven (1 ms at 50 MHz). Legal range ≥ 2.
- `DEBOUNCE_FRAMES`, 5: consecutive identical full-frame scans required before `key` updates. Legal range ≥ 1.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `row_in`  in  4  keypad rows; external pull-up, so 0 means pressed.
- `col_out`  out  4  column drive, active-low; exactly one bit is 0 at any time.
- `key`  out  16  debounced key levels, 1 means held; `key[4*row+col]`.
- `key_press`  out  16  one-cycle pulse on each debounced 0→1 transition of `key`.
- `frame_done`  out  1  one-cycle pulse when a full 4-column frame has been sampled.

## Operation
- **Divider.** `div_cnt` counts 0..SCAN_DIV-1, then wraps. Its width is `$clog2(SCAN_DIV)`.
- **Column counter.**
  - `col` (2 bits) advances when `div_cnt` wraps; it wraps 3→0.
  - `col_out = ~(4'b1 << col)`, registered.
- **Sampling.**
  - `row_in` passes through a 2-flop synchronizer.
  - At `div_cnt == SCAN_DIV-1`, the synchronized rows are written into `raw[4*r+col] = ~row_sync[r]`. This happens before `col` advances, so rows have settled for SCAN_DIV-1 cycles.
  - The sample taken when `col == 3` completes the frame: `frame_done` = 1 on that cycle, and `frame = raw` with column 3 merged in that same cycle.
- **Debounce.** State is `cand[15:0]` and `stab_cnt`, saturating at DEBOUNCE_FRAMES. On each frame completion:
  - If `frame != cand`: `cand <= frame`, `stab_cnt <= 1`.
  - Otherwise: `stab_cnt <= min(stab_cnt+1, DEBOUNCE_FRAMES)`.
  - When the resulting count equals DEBOUNCE_FRAMES, `key <= frame` on the next cycle. With DEBOUNCE_FRAMES = 1, `key` follows every frame.
- **Press strobe.** `key_press = key_next & ~key` is registered together with `key`, so it is high for exactly the cycle in which `key` changes. There is no pulse for releases and no pulse when `key` is unchanged.
- **Multiple keys.** Multiple simultaneous keys are reported as-is. Ghosting is not suppressed; the consumer rejects multi-key patterns.
- **Reset** (asynchronous, any time, including mid-frame):
  - `div_cnt = 0`, `col = 0`, `col_out = 4'b1110`.
  - `raw = 0`, `cand = 0`, `stab_cnt = 0`.
  - `key = 0`, `key_press = 0`, `frame_done = 0`, synchronizer = 4'b1111.
  - Scanning restarts from column 0 on the first clock after release. A partial frame is discarded.

## Timing
- **Frame period:** 4·SCAN_DIV cycles.
  - After reset release, the first `frame_done` comes at cycle 4·SCAN_DIV-1, counting the first clock as 0.
  - Thereafter it repeats every 4·SCAN_DIV cycles.
- **Press latency.** A press is stable on `row_in` from before the sample point of its column in frame k. It is:
  - visible in `frame` at frame k;
  - visible in `key` 1 cycle after frame k+DEBOUNCE_FRAMES-1 completes.
- **Synchronizer delay.** `row_in` must be stable for ≥ 2 cycles before the sample point to be captured.
- **Bounce.** A bounce that changes any bit in any frame restarts the count for the whole vector. `key` holds its old value meanwhile.
- **Counter change at saturation.** If the frame changes while `stab_cnt` is saturated, the count restarts at 1 and `key` stays unchanged until re-qualified.

## Test plan
Use SCAN_DIV=4 and DEBOUNCE_FRAMES=3 unless stated; the frame is 16 cycles.

- **Reset and column walk.** Release reset with no keys pressed.
  - `col_out` must show 1110 for 4 cycles, then 1101, 1011, 0111, then repeat.
  - `frame_done` must pulse at cycles 15, 31, 47, …
  - `key` and `key_press` must stay 0.
- **Single press.** Hold row 2 low whenever column 1 is driven, starting before frame 0.
  - `key == 16'h0200` (bit 9) must appear 1 cycle after the 3rd `frame_done`.
  - `key_press == 16'h0200` must last exactly 1 cycle.
  - Then release the key: `key` returns to 0 three frames later, with no `key_press`.
- **Bounce rejection.** Press key 0 for frames 0–1, open it in frame 2, press it again for frames 3–5.
  - `key[0]` must rise only after frame 5 completes.
  - Exactly one `key_press` pulse is allowed.
- **Two keys.** Press keys 5 and 10 together (row 1/column 1 and row 2/column 2).
  - `key == 16'h0420`.
  - `key_press == 16'h0420` in the same cycle.
- **Mid-frame reset.** Assert `rst_n=0` asynchronously, between edges, during column 2 while key 9 is debounced.
  - All outputs must reach their reset values immediately, without waiting for a clock edge.
  - `col_out` must equal 1110.
  - After release, `key` must rise again only after 3 new frames.
- **Minimum debounce.** With DEBOUNCE_FRAMES=1, toggle key 15 every frame.
  - `key[15]` must follow each frame with 1-cycle latency.
  - `key_press[15]` must pulse on every other frame.
